// File: rtl/load_station.sv
// Load reservation station: buffers load operations until their base operand
// is available (directly or from the broadcast bus), then issues them in index order.
module load_station #(
  parameter int unsigned DEPTH      = 3,
  parameter logic [4:0]  LABEL_BASE = 5'd13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EXEable,
  input  logic        WEN,
  input  logic [4:0]  opCode,
  input  logic [4:0]  func,
  input  logic [31:0] dataIn1,
  input  logic [4:0]  label1,
  input  logic [31:0] Imm,
  input  logic        BCEN,
  input  logic [4:0]  BClabel,
  input  logic [31:0] BCdata,
  output logic [4:0]  opOut,
  output logic [31:0] dataOut1,
  output logic [31:0] dataOut2,
  output logic        isFull,
  output logic        OutEn,
  output logic [4:0]  labelOut
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] busy;
  logic [4:0]       op_q  [DEPTH];
  logic [4:0]       fn_q  [DEPTH];
  logic [31:0]      val_q [DEPTH];
  logic [4:0]       tag_q [DEPTH];
  logic [31:0]      imm_q [DEPTH];

  logic [IW-1:0]    isel, wsel;
  logic             ifound, wfound;
  logic             wake_in;
  logic             unused_fn;

  // Lowest-index ready entry for issue, lowest-index free entry for write.
  always_comb begin
    isel      = '0;
    ifound    = 1'b0;
    wsel      = '0;
    wfound    = 1'b0;
    unused_fn = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (busy[i] && (tag_q[i] == 5'd0) && !ifound) begin
        isel   = IW'(i);
        ifound = 1'b1;
      end
      if (!busy[i] && !wfound) begin
        wsel   = IW'(i);
        wfound = 1'b1;
      end
      unused_fn = unused_fn ^ (^fn_q[i]);
    end
  end

  assign isFull  = &busy;
  assign wake_in = (label1 != 5'd0) && BCEN && (BClabel == label1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= '0;
      opOut    <= '0;
      dataOut1 <= '0;
      dataOut2 <= '0;
      labelOut <= '0;
      OutEn    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        fn_q[i]  <= '0;
        val_q[i] <= '0;
        tag_q[i] <= '0;
        imm_q[i] <= '0;
      end
    end else begin
      if (EXEable && ifound) begin
        opOut      <= op_q[isel];
        dataOut1   <= val_q[isel];
        dataOut2   <= imm_q[isel];
        labelOut   <= LABEL_BASE + 5'(isel);
        OutEn      <= 1'b1;
        busy[isel] <= 1'b0;
      end else begin
        OutEn <= 1'b0;
      end

      // Tag 0 means ready, so a zero BClabel can never wake anything.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (BCEN && busy[i] && (tag_q[i] != 5'd0) && (tag_q[i] == BClabel)) begin
          val_q[i] <= BCdata;
          tag_q[i] <= 5'd0;
        end
      end

      // Write target is non-busy pre-edge, so it never collides with snoop or issue.
      if (WEN && !isFull) begin
        busy[wsel]  <= 1'b1;
        op_q[wsel]  <= opCode;
        fn_q[wsel]  <= func;
        imm_q[wsel] <= Imm;
        if (label1 == 5'd0) begin
          val_q[wsel] <= dataIn1;
          tag_q[wsel] <= 5'd0;
        end else if (wake_in) begin
          val_q[wsel] <= BCdata;
          tag_q[wsel] <= 5'd0;
        end else begin
          val_q[wsel] <= dataIn1;
          tag_q[wsel] <= label1;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_station.sv
// Directed table-driven bench for load_station (DEPTH=3, tags 13..15).
module tb_load_station;

  logic        clk;
  logic        rst_n;
  logic        EXEable;
  logic        WEN;
  logic [4:0]  opCode;
  logic [4:0]  func;
  logic [31:0] dataIn1;
  logic [4:0]  label1;
  logic [31:0] Imm;
  logic        BCEN;
  logic [4:0]  BClabel;
  logic [31:0] BCdata;
  logic [4:0]  opOut;
  logic [31:0] dataOut1;
  logic [31:0] dataOut2;
  logic        isFull;
  logic        OutEn;
  logic [4:0]  labelOut;

  load_station #(.DEPTH(3), .LABEL_BASE(5'd13)) dut (
    .clk(clk), .rst_n(rst_n), .EXEable(EXEable), .WEN(WEN),
    .opCode(opCode), .func(func), .dataIn1(dataIn1), .label1(label1),
    .Imm(Imm), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata),
    .opOut(opOut), .dataOut1(dataOut1), .dataOut2(dataOut2),
    .isFull(isFull), .OutEn(OutEn), .labelOut(labelOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, exe, wen;
    logic [4:0]  op;
    logic [31:0] d1;
    logic [4:0]  l1;
    logic [31:0] imm;
    logic        bcen;
    logic [4:0]  bcl;
    logic [31:0] bcd;
    logic        e_en;
    logic [4:0]  e_op;
    logic [31:0] e_d1, e_d2;
    logic [4:0]  e_lab;
    logic        e_full;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic v(input logic r, input logic e, input logic w, input logic [4:0] op,
                   input logic [31:0] d1, input logic [4:0] l1, input logic [31:0] imm,
                   input logic bc, input logic [4:0] bl, input logic [31:0] bd,
                   input logic xen, input logic [4:0] xop, input logic [31:0] xd1,
                   input logic [31:0] xd2, input logic [4:0] xlab, input logic xfull);
    vec_t t;
    t = '{r, e, w, op, d1, l1, imm, bc, bl, bd, xen, xop, xd1, xd2, xlab, xfull};
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic w, input logic [4:0] op,
                       input logic [31:0] d1, input logic [4:0] l1, input logic [31:0] imm,
                       input logic bc, input logic [4:0] bl, input logic [31:0] bd);
    rst_n = r; EXEable = e; WEN = w; opCode = op; func = op ^ 5'h15;
    dataIn1 = d1; label1 = l1; Imm = imm; BCEN = bc; BClabel = bl; BCdata = bd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit got;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //  rst exe wen op d1 l1 imm  bc bl bd   | en op d1  d2  lab full
    v(0, 0, 0, 0,  0, 0, 0,   0, 0, 0,   0, 0,  0,  0,   0,  0); // reset
    v(1, 0, 1, 2,  4, 0, 1,   0, 0, 0,   0, 0,  0,  0,   0,  0); // ready write
    v(1, 1, 0, 0,  0, 0, 0,   0, 0, 0,   1, 2,  4,  1,   13, 0); // issue
    v(1, 1, 0, 0,  0, 0, 0,   0, 0, 0,   0, 2,  4,  1,   13, 0); // hold
    v(1, 1, 1, 1,  7, 2, 100, 0, 0, 0,   0, 2,  4,  1,   13, 0); // wait tag 2
    v(1, 1, 0, 0,  0, 0, 0,   0, 0, 0,   0, 2,  4,  1,   13, 0);
    v(1, 1, 0, 0,  0, 0, 0,   1, 2, 32,  0, 2,  4,  1,   13, 0); // broadcast
    v(1, 1, 0, 0,  0, 0, 0,   0, 0, 0,   1, 1,  32, 100, 13, 0);
    v(1, 1, 1, 3,  9, 2, 8,   1, 2, 32,  0, 1,  32, 100, 13, 0); // same-edge forward
    v(1, 1, 0, 0,  0, 0, 0,   0, 0, 0,   1, 3,  32, 8,   13, 0);
    v(1, 0, 1, 4,  0, 3, 5,   0, 0, 0,   0, 3,  32, 8,   13, 0); // wait tag 3
    v(1, 1, 0, 0,  0, 0, 0,   1, 4, 99,  0, 3,  32, 8,   13, 0); // wrong tag
    v(1, 1, 0, 0,  0, 0, 0,   0, 0, 0,   0, 3,  32, 8,   13, 0);
    v(1, 1, 0, 0,  0, 0, 0,   1, 3, 77,  0, 3,  32, 8,   13, 0);
    v(1, 1, 0, 0,  0, 0, 0,   0, 0, 0,   1, 4,  77, 5,   13, 0);
    v(1, 1, 1, 5,  0, 5, 10,  0, 0, 0,   0, 4,  77, 5,   13, 0); // fill
    v(1, 1, 1, 6,  0, 5, 11,  0, 0, 0,   0, 4,  77, 5,   13, 0);
    v(1, 1, 1, 7,  0, 5, 12,  0, 0, 0,   0, 4,  77, 5,   13, 1);
    v(1, 0, 1, 8,  1, 0, 13,  0, 0, 0,   0, 4,  77, 5,   13, 1); // ignored write
    v(1, 1, 0, 0,  0, 0, 0,   1, 5, 50,  0, 4,  77, 5,   13, 1);
    v(1, 1, 1, 9,  2, 0, 14,  0, 0, 0,   1, 5,  50, 10,  13, 0); // write while full+issue
    v(1, 1, 0, 0,  0, 0, 0,   0, 0, 0,   1, 6,  50, 11,  14, 0);
    v(1, 1, 0, 0,  0, 0, 0,   0, 0, 0,   1, 7,  50, 12,  15, 0);
    v(1, 1, 0, 0,  0, 0, 0,   0, 0, 0,   0, 7,  50, 12,  15, 0);
    v(1, 0, 1, 10, 0, 6, 1,   0, 0, 0,   0, 7,  50, 12,  15, 0);
    v(1, 0, 1, 11, 0, 6, 2,   0, 0, 0,   0, 7,  50, 12,  15, 0);
    v(0, 1, 1, 12, 3, 0, 4,   1, 6, 5,   0, 0,  0,  0,   0,  0); // reset mid-run
    v(1, 1, 0, 0,  0, 0, 0,   1, 6, 5,   0, 0,  0,  0,   0,  0);
    v(1, 1, 0, 0,  0, 0, 0,   0, 0, 0,   0, 0,  0,  0,   0,  0);
    v(1, 1, 1, 12, 3, 0, 4,   0, 0, 0,   0, 0,  0,  0,   0,  0); // write+issue overlap
    v(1, 1, 1, 13, 5, 0, 6,   0, 0, 0,   1, 12, 3,  4,   13, 0);
    v(1, 1, 0, 0,  0, 0, 0,   0, 0, 0,   1, 13, 5,  6,   14, 0);
    v(1, 1, 0, 0,  0, 0, 0,   0, 0, 0,   0, 13, 5,  6,   14, 0);

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].exe, tbl[i].wen, tbl[i].op, tbl[i].d1, tbl[i].l1,
            tbl[i].imm, tbl[i].bcen, tbl[i].bcl, tbl[i].bcd);
      tick();
      chk($sformatf("v%0d.OutEn", i),    32'(OutEn),    32'(tbl[i].e_en));
      chk($sformatf("v%0d.opOut", i),    32'(opOut),    32'(tbl[i].e_op));
      chk($sformatf("v%0d.dataOut1", i), dataOut1,      tbl[i].e_d1);
      chk($sformatf("v%0d.dataOut2", i), dataOut2,      tbl[i].e_d2);
      chk($sformatf("v%0d.labelOut", i), 32'(labelOut), 32'(tbl[i].e_lab));
      chk($sformatf("v%0d.isFull", i),   32'(isFull),   32'(tbl[i].e_full));
    end

    // Out-of-order wakeup: middle entry woken first issues with tag 14.
    drive(1, 0, 1, 20, 0, 9, 40, 0, 0, 0);  tick();
    drive(1, 0, 1, 21, 0, 10, 41, 0, 0, 0); tick();
    drive(1, 0, 1, 22, 0, 11, 42, 0, 0, 0); tick();
    chk("seq.full", 32'(isFull), 32'd1);
    drive(1, 1, 0, 0, 0, 0, 0, 1, 10, 32'hCAFE); tick();
    chk("seq.no_early_issue", 32'(OutEn), 32'd0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      tick();
      if (OutEn) got = 1'b1;
    end
    chk("seq.issue_seen", 32'(got), 32'd1);
    chk("seq.labelOut", 32'(labelOut), 32'd14);
    chk("seq.dataOut1", dataOut1, 32'hCAFE);
    chk("seq.dataOut2", dataOut2, 32'd41);
    chk("seq.opOut", 32'(opOut), 32'd21);
    chk("seq.not_full", 32'(isFull), 32'd0);
    tick();
    chk("seq.single_issue", 32'(OutEn), 32'd0);

    // Broadcast with tag 0 must not wake pending entries.
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0, 32'd1); tick();
    tick();
    chk("seq.bclabel0", 32'(OutEn), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_station.md
LOAD_STATION -- requirements
Module: load_station

Interface
- REQ-001 Parameter DEPTH, default 3: number of station entries.
- REQ-002 Parameter LABEL_BASE, default 5'd13: tag of entry 0; entry i is tagged LABEL_BASE+i.
- REQ-003 Clocking/reset: one clock; reset is synchronous and active-low. All state changes on the rising edge of clk.
- REQ-004 clk  in  1  clock.
- REQ-005 rst_n  in  1  synchronous active-low reset.
- REQ-006 EXEable  in  1  load unit can accept an operation this cycle.
- REQ-007 WEN  in  1  write enable; allocate a new entry.
- REQ-008 opCode  in  5  operation code of incoming load.
- REQ-009 func  in  5  function field of incoming load.
- REQ-010 dataIn1  in  32  base-register value; valid only when label1==0.
- REQ-011 label1  in  5  producer tag of base register; 0 = value ready.
- REQ-012 Imm  in  32  address offset.
- REQ-013 BCEN  in  1  common-data-bus broadcast valid.
- REQ-014 BClabel  in  5  broadcast producer tag.
- REQ-015 BCdata  in  32  broadcast value.
- REQ-016 opOut  out  5  opCode of the issued entry.
- REQ-017 dataOut1  out  32  base value of the issued entry.
- REQ-018 dataOut2  out  32  Imm of the issued entry.
- REQ-019 isFull  out  1  all DEPTH entries busy (combinational from state).
- REQ-020 OutEn  out  1  opOut/dataOut1/dataOut2/labelOut valid this cycle.
- REQ-021 labelOut  out  5  tag (LABEL_BASE+i) of the issued entry.

Function
- REQ-022 Each entry holds: busy, op, func, value, tag, imm.
- REQ-023 Write: at an edge with WEN=1 and isFull=0, the lowest-index non-busy entry is loaded and set busy. WEN=1 while isFull=1 is ignored, even if an entry issues on the same edge.
- REQ-024 An incoming entry with label1 != 0 captures BCdata and gets tag 0 if BCEN=1 and BClabel==label1 on the write edge.
- REQ-025 Snoop: at every edge with BCEN=1, each busy entry with tag != 0 and tag == BClabel captures BCdata and sets tag to 0. BClabel=0 never matches.
- REQ-026 An entry is ready when busy and tag == 0, evaluated from state before the edge. An entry written or woken on an edge is first eligible on the following edge.
- REQ-027 Issue: at an edge with EXEable=1 and at least one ready entry, the lowest-index ready entry i is selected.
  - Outputs are registered: opOut=op, dataOut1=value, dataOut2=imm, labelOut=LABEL_BASE+i, OutEn=1.
  - Entry i becomes non-busy on the same edge.
  - At most one issue per edge.
- REQ-028 At an edge with EXEable=0 or no ready entry, OutEn becomes 0; opOut/dataOut1/dataOut2/labelOut hold their previous values.
- REQ-029 isFull = AND of busy over all entries; it deasserts in the cycle after an issue from a full station.
- REQ-030 Write, snoop and issue may occur on the same edge. They are independent because issue uses pre-edge readiness and write uses pre-edge isFull.
- REQ-031 func is stored but not output.
- REQ-032 With DEPTH=3 an implementation is 120-400 lines.

Reset
- REQ-033 When rst_n=0 at an edge: all entries non-busy; opOut=0, dataOut1=0, dataOut2=0, labelOut=0, OutEn=0; isFull=0 afterwards. Reset overrides write, snoop and issue on that edge.
- REQ-034 Reset asserted mid-operation discards all pending entries; no issue occurs on the reset edge.

Verification
- REQ-035 Ready write then issue: WEN=1, opCode=2, dataIn1=4, label1=0, Imm=1 with EXEable=0; then EXEable=1 -> next edge OutEn=1, opOut=2, dataOut1=4, dataOut2=1, labelOut=13, and the entry is freed.
- REQ-036 Wait for broadcast: write opCode=1, label1=2, Imm=100; EXEable=1 and no broadcast -> OutEn stays 0. Then BCEN=1, BClabel=2, BCdata=32 for one edge -> following edge OutEn=1, dataOut1=32, dataOut2=100.
- REQ-037 Same-edge forwarding: WEN=1, label1=2 together with BCEN=1, BClabel=2, BCdata=32 -> stored value 32, ready; issues one edge later when EXEable=1.
- REQ-038 Full: three writes with label1=5 -> isFull=1; a fourth WEN=1 is ignored. Broadcast BClabel=5 with EXEable=1 -> three issues on consecutive edges with labelOut 13, 14, 15; isFull=0 after the first issue.
- REQ-039 Mismatched broadcast: entry with label1=3 and BCEN=1, BClabel=4 -> entry stays not ready, OutEn=0.
- REQ-040 Reset mid-run: two busy entries, rst_n=0 for one edge -> OutEn=0, isFull=0, all outputs 0, no later issue without new writes.
